// File: rtl/mam_mem_arbiter.sv
// Two-requester arbiter for the osd_mam memory port: round-robin grant, held for a whole
// transaction (request plus all write/read beats), with beats passed through combinationally.
module mam_mem_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [1:0]                  s_req_valid,
  output logic [1:0]                  s_req_ready,
  input  logic [1:0]                  s_req_rw,
  input  logic [2*ADDR_WIDTH-1:0]     s_req_addr,
  input  logic [1:0]                  s_req_burst,
  input  logic [27:0]                 s_req_beats,
  input  logic [1:0]                  s_write_valid,
  output logic [1:0]                  s_write_ready,
  input  logic [2*DATA_WIDTH-1:0]     s_write_data,
  input  logic [2*DATA_WIDTH/8-1:0]   s_write_strb,
  output logic [1:0]                  s_read_valid,
  input  logic [1:0]                  s_read_ready,
  output logic [DATA_WIDTH-1:0]       s_read_data,
  output logic                        m_req_valid,
  input  logic                        m_req_ready,
  output logic                        m_req_rw,
  output logic [ADDR_WIDTH-1:0]       m_req_addr,
  output logic                        m_req_burst,
  output logic [13:0]                 m_req_beats,
  output logic                        m_write_valid,
  input  logic                        m_write_ready,
  output logic [DATA_WIDTH-1:0]       m_write_data,
  output logic [DATA_WIDTH/8-1:0]     m_write_strb,
  input  logic                        m_read_valid,
  input  logic [DATA_WIDTH-1:0]       m_read_data,
  output logic                        m_read_ready,
  output logic [1:0]                  grant,
  output logic                        busy,
  output logic [1:0]                  dbg_state_o
);

  localparam int SW = DATA_WIDTH / 8;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready; the
  // non-granted requester always sees its readies and s_read_valid at 0.
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WRITE, ST_READ} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        ptr_q, ptr_d;
  logic [13:0] cnt_q, cnt_d;

  logic        gidx;
  logic [13:0] beats_g;
  logic [13:0] load_cnt;
  logic        write_hs;
  logic        read_hs;

  assign gidx     = grant_q[1];
  assign beats_g  = gidx ? s_req_beats[27:14] : s_req_beats[13:0];
  // A burst of zero beats still moves one beat.
  assign load_cnt = s_req_burst[gidx] ? ((beats_g == 14'd0) ? 14'd1 : beats_g) : 14'd1;
  assign write_hs = (state_q == ST_WRITE) && s_write_valid[gidx] && m_write_ready;
  assign read_hs  = (state_q == ST_READ) && m_read_valid && s_read_ready[gidx];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= 14'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (s_req_valid != 2'b00) begin
          if (s_req_valid[ptr_q]) grant_d = ptr_q ? 2'b10 : 2'b01;
          else                    grant_d = ptr_q ? 2'b01 : 2'b10;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!s_req_valid[gidx]) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else if (m_req_ready) begin
          cnt_d   = load_cnt;
          state_d = s_req_rw[gidx] ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE, ST_READ: begin
        if (write_hs || read_hs) begin
          cnt_d = cnt_q - 14'd1;
          if (cnt_q == 14'd1) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            ptr_d   = ~gidx;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_req_ready   = 2'b00;
    s_write_ready = 2'b00;
    s_read_valid  = 2'b00;
    m_req_valid   = 1'b0;
    m_write_valid = 1'b0;
    m_read_ready  = 1'b0;
    case (state_q)
      ST_REQ: begin
        m_req_valid       = s_req_valid[gidx];
        s_req_ready[gidx] = m_req_ready;
      end
      ST_WRITE: begin
        m_write_valid       = s_write_valid[gidx];
        s_write_ready[gidx] = m_write_ready;
      end
      ST_READ: begin
        s_read_valid[gidx] = m_read_valid;
        m_read_ready       = s_read_ready[gidx];
      end
      default: ;
    endcase
  end

  // Data paths follow the owner; requester 0 when idle.
  assign m_req_rw     = s_req_rw[gidx];
  assign m_req_burst  = s_req_burst[gidx];
  assign m_req_beats  = beats_g;
  assign m_req_addr   = gidx ? s_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_req_addr[ADDR_WIDTH-1:0];
  assign m_write_data = gidx ? s_write_data[2*DATA_WIDTH-1:DATA_WIDTH] : s_write_data[DATA_WIDTH-1:0];
  assign m_write_strb = gidx ? s_write_strb[2*SW-1:SW] : s_write_strb[SW-1:0];
  assign s_read_data  = m_read_data;

  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/mam_mem_arbiter.md
# mam_mem_arbiter

Two-port arbiter that shares one memory request/write/read port (the interface driven by `osd_mam`: `req_*`, `write_*`, `read_*`) between two requesters, e.g. the debug-system MAM and a second MAM or trace DMA engine. It serializes whole transactions. A grant is held from request acceptance until the last write or read beat, so write and read bursts never interleave. Round-robin priority keeps both requesters from starving. It sits between the requesters and the memory-side AXI/NASTI adapter.

## Interface
- `DATA_WIDTH`, 512, width of the write and read data beats.
- `ADDR_WIDTH`, 64, width of the request address.
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `s_req_valid` in 2: per-requester request valid; index i is requester i.
- `s_req_ready` out 2: per-requester request accept.
- `s_req_rw` in 2: 1 = write, 0 = read.
- `s_req_addr` in 2*ADDR_WIDTH: requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `s_req_burst` in 2: 1 = burst of `s_req_beats` beats, 0 = single beat.
- `s_req_beats` in 2*14: beat count, 14 bits per requester.
- `s_write_valid`, `s_write_ready` in/out 2: write beat handshake.
- `s_write_data` in 2*DATA_WIDTH; `s_write_strb` in 2*DATA_WIDTH/8.
- `s_read_valid` out 2; `s_read_ready` in 2; `s_read_data` out DATA_WIDTH (broadcast to both requesters).
- `m_req_valid`, `m_req_ready`, `m_req_rw`, `m_req_addr`, `m_req_burst`, `m_req_beats`: memory-side request (out, in, out, out ADDR_WIDTH, out, out 14).
- `m_write_valid` out, `m_write_ready` in, `m_write_data` out DATA_WIDTH, `m_write_strb` out DATA_WIDTH/8.
- `m_read_valid` in, `m_read_data` in DATA_WIDTH, `m_read_ready` out.
- `grant` out 2: one-hot owner, 0 when idle.
- `busy` out 1: high in any state except IDLE.

## Operation
- The FSM has four states: IDLE, REQ, WRITE, READ.
- **IDLE**
  - If any `s_req_valid` is set, register `grant`: the requester at the priority pointer if it is valid, else the other one. Go to REQ.
  - All `s_*_ready`, `s_read_valid` and `m_*_valid` are 0.
- **REQ**
  - `m_req_*` is muxed combinationally from the granted requester. `s_req_ready[g] = m_req_ready`.
  - On handshake (`m_req_valid && m_req_ready`), load the beat counter: `s_req_burst ? max(s_req_beats,1) : 1`. Go to WRITE if `rw` = 1, else READ.
  - If `s_req_valid[g]` drops before the handshake, return to IDLE with no pointer change.
- **WRITE**
  - `m_write_*` is muxed from requester g. `s_write_ready[g] = m_write_ready`.
  - Each write handshake decrements the counter. The handshake that takes the counter to 0 goes to IDLE.
- **READ**
  - `s_read_valid[g] = m_read_valid` and `m_read_ready = s_read_ready[g]`.
  - Each read handshake decrements the counter; the last one goes to IDLE.
- **Completion**: when a transaction completes (last beat), the priority pointer moves to the non-granted requester and `grant` clears.
- **Non-granted requester**: sees all readies and `s_read_valid` at 0 at all times.
- **Output values**
  - `m_req_*`, `m_write_*` data outputs carry the granted requester's inputs (requester 0's when idle).
  - Their `valid`s are gated to 0 outside the owning state.

## Timing
- **Reset values** (`rstn` = 0, async): state IDLE, `grant` = 0, pointer = 0, `busy` = 0, counter = 0, all valid and ready outputs 0.
- **Arbitration latency**: exactly 1 cycle. A request seen in IDLE at edge n makes `m_req_valid` = 1 in cycle n+1.
- **Bubble**: 1 IDLE cycle between back-to-back transactions; peak request rate is one per (beats + 2) cycles.
- **Beat path**: write/read beats pass through combinationally with zero added latency and full throughput (one beat per cycle).
- **Simultaneous requests**: the pointer decides. After reset, requester 0 wins first.
- **Burst length**: 14-bit counter. Burst with beats = 0 counts as 1 beat. Maximum burst is 16383 beats; there is no wrap.
- **Reset mid-transaction**: immediately returns to IDLE. Any outstanding memory-side burst is abandoned; the memory side must be reset together with the arbiter.
- **Early write data**: write beats presented before the handshake are not accepted (`s_write_ready` = 0 until WRITE).

## Test plan
- **Single read**: req0 read, addr 0x1000, burst = 0 → `m_req_valid` the cycle after the request, addr 0x1000; one read beat to requester 0; `grant` 01 → 00; `busy` falls 1 cycle after the beat.
- **Simultaneous writes**: both request write bursts of 4 beats at the same edge after reset → requester 0's 4 beats complete first, then requester 1's; `s_req_ready[1]` stays 0 until requester 0's 4th beat.
- **Round-robin**: requester 0 requests continuously and requester 1 requests once → grants alternate 0, 1, 0; requester 1 waits at most one transaction.
- **Beat count edge cases**: burst = 1 with beats = 0 → exactly 1 beat. Beats = 3 with `m_write_ready` toggled 1,0,1,0,1 → 3 beats counted, then IDLE.
- **Request withdrawal**: requester 1 drops `s_req_valid` in REQ while `m_req_ready` = 0 → back to IDLE, pointer unchanged, no beats issued.
- **Reset mid-burst**: `rstn` asserted mid-burst during beat 2 of 8 → all valids and readies 0 asynchronously, `grant` 0; after reset release, a new request from requester 0 is granted first.
